// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller: flush_and_stall encoding
// and the fetch/data-wait sequencer states.
package pipeline_pkg;

   typedef logic [1:0] fs_t;

   localparam fs_t FS_RUN   = 2'b00;
   localparam fs_t FS_STALL = 2'b01;
   localparam fs_t FS_FLUSH = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DWAIT,
      ST_IWAIT,
      ST_IDISCARD
   } ctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the register being
// loaded by the instruction currently in EX (x0 never creates a hazard).
module load_use_detect (
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   output logic       hazard
);

   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
      rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
      hazard  = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: data-memory waits, branch
// redirects (including ones deferred behind an unabortable fetch), load-use.
module pipeline_hazard_ctrl #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  imem_req,
   input  logic                  imem_ack,
   input  logic                  dmem_req,
   input  logic                  dmem_ack,
   input  logic [4:0]            id_rs1,
   input  logic [4:0]            id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [4:0]            ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  ex_branch_taken,
   input  logic [ADDR_WIDTH-1:0] ex_target,
   output logic                  pc_write,
   output logic                  pc_redirect,
   output logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic [1:0]            ifid_fs,
   output logic [1:0]            idex_fs,
   output logic [1:0]            exmem_fs,
   output logic [1:0]            memwb_fs,
   output logic [CNT_WIDTH-1:0]  stall_cycles
);

   import pipeline_pkg::*;

   ctrl_state_t           state_q, state_d;
   ctrl_state_t           ret_q, ret_d;
   logic                  pend_valid_q, pend_valid_d;
   logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
   logic [CNT_WIDTH-1:0]  stall_q, stall_d;

   logic                  load_use;
   logic                  imem_wait;
   logic                  dmem_wait;
   ctrl_state_t           fetch_st;
   fs_t                   ifid_c, idex_c, exmem_c, memwb_c;
   logic                  pcw_c;
   logic                  redir_c;
   logic [ADDR_WIDTH-1:0] rpc_c;

   load_use_detect u_load_use_detect (
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .hazard      (load_use)
   );

   always_comb begin
      imem_wait    = imem_req && !imem_ack;
      dmem_wait    = dmem_req && !dmem_ack;
      // DWAIT overlays the fetch state; ret_q remembers which one to resume
      fetch_st     = (state_q == ST_DWAIT) ? ret_q : state_q;

      state_d      = state_q;
      ret_d        = ret_q;
      pend_valid_d = pend_valid_q;
      pend_pc_d    = pend_pc_q;
      ifid_c       = FS_RUN;
      idex_c       = FS_RUN;
      exmem_c      = FS_RUN;
      memwb_c      = FS_RUN;
      pcw_c        = 1'b1;
      redir_c      = 1'b0;
      rpc_c        = pend_valid_q ? pend_pc_q : ex_target;

      if (dmem_wait) begin
         ifid_c  = FS_STALL;
         idex_c  = FS_STALL;
         exmem_c = FS_STALL;
         memwb_c = FS_FLUSH;
         pcw_c   = 1'b0;
         state_d = ST_DWAIT;
         ret_d   = fetch_st;
      end else if (fetch_st == ST_IDISCARD) begin
         if (ex_branch_taken) begin
            pend_pc_d = ex_target;
         end
         ifid_c = FS_FLUSH;
         if (imem_ack) begin
            redir_c      = 1'b1;
            pend_valid_d = 1'b0;
            state_d      = ST_RUN;
         end else begin
            pcw_c   = 1'b0;
            state_d = ST_IDISCARD;
         end
      end else if (ex_branch_taken) begin
         ifid_c = FS_FLUSH;
         idex_c = FS_FLUSH;
         if (imem_wait) begin
            pcw_c        = 1'b0;
            pend_pc_d    = ex_target;
            pend_valid_d = 1'b1;
            state_d      = ST_IDISCARD;
         end else begin
            redir_c = 1'b1;
            state_d = ST_RUN;
         end
      end else if (load_use) begin
         pcw_c   = 1'b0;
         ifid_c  = FS_STALL;
         idex_c  = FS_FLUSH;
         state_d = imem_wait ? ST_IWAIT : ST_RUN;
      end else if (imem_wait) begin
         pcw_c   = 1'b0;
         ifid_c  = FS_FLUSH;
         state_d = ST_IWAIT;
      end else begin
         state_d = ST_RUN;
      end

      stall_d = stall_q;
      if (!pcw_c && (stall_q != '1)) begin
         stall_d = stall_q + CNT_WIDTH'(1);
      end

      // Reset forces a quiet pipeline regardless of inputs
      if (reset) begin
         ifid_fs     = FS_RUN;
         idex_fs     = FS_RUN;
         exmem_fs    = FS_RUN;
         memwb_fs    = FS_RUN;
         pc_write    = 1'b0;
         pc_redirect = 1'b0;
         redirect_pc = '0;
      end else begin
         ifid_fs     = ifid_c;
         idex_fs     = idex_c;
         exmem_fs    = exmem_c;
         memwb_fs    = memwb_c;
         pc_write    = pcw_c;
         pc_redirect = redir_c;
         redirect_pc = rpc_c;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_RUN;
         ret_q        <= ST_RUN;
         pend_valid_q <= 1'b0;
         pend_pc_q    <= '0;
         stall_q      <= '0;
      end else begin
         state_q      <= state_d;
         ret_q        <= ret_d;
         pend_valid_q <= pend_valid_d;
         pend_pc_q    <= pend_pc_d;
         stall_q      <= stall_d;
      end
   end

   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

   logic        clk;
   logic        reset;
   logic        imem_req, imem_ack, dmem_req, dmem_ack;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
   logic [31:0] ex_target;
   logic        pc_write, pc_redirect;
   logic [31:0] redirect_pc;
   logic [1:0]  ifid_fs, idex_fs, exmem_fs, memwb_fs;
   logic [31:0] stall_cycles;

   int unsigned err_cnt = 0;
   int unsigned chk_cnt = 0;

   pipeline_hazard_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req        (imem_req),
      .imem_ack        (imem_ack),
      .dmem_req        (dmem_req),
      .dmem_ack        (dmem_ack),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_use_rs1      (id_use_rs1),
      .id_use_rs2      (id_use_rs2),
      .ex_rd           (ex_rd),
      .ex_mem_read     (ex_mem_read),
      .ex_branch_taken (ex_branch_taken),
      .ex_target       (ex_target),
      .pc_write        (pc_write),
      .pc_redirect     (pc_redirect),
      .redirect_pc     (redirect_pc),
      .ifid_fs         (ifid_fs),
      .idex_fs         (idex_fs),
      .exmem_fs        (exmem_fs),
      .memwb_fs        (memwb_fs),
      .stall_cycles    (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic [1:0] e_ifid, input logic [1:0] e_idex,
                          input logic [1:0] e_exmem, input logic [1:0] e_memwb,
                          input logic e_pcw, input logic e_redir);
      chk({tag, "_ifid"},  64'(ifid_fs),     64'(e_ifid));
      chk({tag, "_idex"},  64'(idex_fs),     64'(e_idex));
      chk({tag, "_exmem"}, 64'(exmem_fs),    64'(e_exmem));
      chk({tag, "_memwb"}, 64'(memwb_fs),    64'(e_memwb));
      chk({tag, "_pcw"},   64'(pc_write),    64'(e_pcw));
      chk({tag, "_redir"}, 64'(pc_redirect), 64'(e_redir));
   endtask

   task automatic idle();
      imem_req = 0; imem_ack = 0; dmem_req = 0; dmem_ack = 0;
      id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_rd = 0; ex_mem_read = 0; ex_branch_taken = 0; ex_target = 32'h0;
   endtask

   // inputs are applied 1 time unit after the rising edge; #2 later outputs are sampled
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      ex_branch_taken = 1'b1;
      ex_target = 32'hCAFE_0000;
      imem_req = 1'b1;
      #2;
      chk_ctl("rst", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
      chk("rst_rpc", 64'(redirect_pc), 64'h0);
      chk("rst_cnt", 64'(stall_cycles), 64'h0);
      step(); step();
      idle();
      reset = 1'b0;
      #2;
      chk_ctl("idle", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
      step();

      // lw x5 in EX, add x6,x5,x1 in ID
      ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd1; id_use_rs1 = 1; id_use_rs2 = 1;
      #2;
      chk_ctl("lu", 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
      step();
      ex_mem_read = 0; ex_rd = 5'd0;
      #2;
      chk_ctl("lu_after", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
      chk("lu_cnt", 64'(stall_cycles), 64'd1);
      step();

      // load to x0 never stalls
      ex_mem_read = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1; id_use_rs2 = 0;
      #2;
      chk("x0_pcw", 64'(pc_write), 64'd1);
      chk("x0_ifid", 64'(ifid_fs), 64'd0);
      step();
      // rs2 match only counts when rs2 is used
      ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_use_rs2 = 0;
      #2;
      chk("rs2_unused_pcw", 64'(pc_write), 64'd1);
      id_use_rs2 = 1;
      #1;
      chk_ctl("rs2_lu", 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
      step();
      idle();
      #2;
      chk("rs2_cnt", 64'(stall_cycles), 64'd2);

      // taken branch, fetch idle
      ex_branch_taken = 1; ex_target = 32'h8000_0040;
      #1;
      chk_ctl("br", 2'b10, 2'b10, 2'b00, 2'b00, 1'b1, 1'b1);
      chk("br_rpc", 64'(redirect_pc), 64'h8000_0040);
      step();
      idle();
      #2;
      chk_ctl("br_after", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
      step();

      // taken branch while fetch outstanding, ack low for 3 cycles
      imem_req = 1; ex_branch_taken = 1; ex_target = 32'h1234_5678;
      #2;
      chk_ctl("ibr_w1", 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
      step();
      ex_branch_taken = 0; ex_target = 32'hDEAD_BEEF;
      for (int i = 0; i < 2; i++) begin
         #2;
         chk_ctl($sformatf("ibr_w%0d", i + 2), 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
         step();
      end
      imem_ack = 1;
      #2;
      chk_ctl("ibr_ack", 2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
      chk("ibr_rpc", 64'(redirect_pc), 64'h1234_5678);
      chk("ibr_cnt", 64'(stall_cycles), 64'd5);
      step();
      imem_req = 1; imem_ack = 1;
      #2;
      chk_ctl("ibr_after", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
      step();
      idle();

      // dmem wait for 4 cycles with a branch held in EX
      dmem_req = 1; ex_branch_taken = 1; ex_target = 32'h8000_0100;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk_ctl($sformatf("dw%0d", i), 2'b01, 2'b01, 2'b01, 2'b10, 1'b0, 1'b0);
         step();
      end
      dmem_ack = 1;
      #2;
      chk_ctl("dw_ack", 2'b10, 2'b10, 2'b00, 2'b00, 1'b1, 1'b1);
      chk("dw_rpc", 64'(redirect_pc), 64'h8000_0100);
      step();
      idle();
      #2;
      chk("dw_cnt", 64'(stall_cycles), 64'd9);

      // imem wait only
      imem_req = 1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk_ctl($sformatf("iw%0d", i), 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
         step();
      end
      imem_ack = 1;
      #2;
      chk_ctl("iw_ack", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
      chk("iw_cnt", 64'(stall_cycles), 64'd11);
      step();
      idle();

      // reset while a redirect is pending behind a fetch
      imem_req = 1; ex_branch_taken = 1; ex_target = 32'h0000_0AB0;
      step();
      ex_branch_taken = 0;
      #2;
      chk("rd_wait_pcw", 64'(pc_write), 64'd0);
      reset = 1'b1;
      #1;
      chk_ctl("rd_rst", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
      chk("rd_rst_cnt", 64'(stall_cycles), 64'd0);
      chk("rd_rst_rpc", 64'(redirect_pc), 64'h0);
      step();
      reset = 1'b0;
      imem_ack = 1;
      ex_target = 32'h0000_0200;
      #2;
      chk_ctl("rd_post", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
      chk("rd_post_rpc", 64'(redirect_pc), 64'h0000_0200);
      step();
      idle();
      #2;
      chk("rd_post_cnt", 64'(stall_cycles), 64'd0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
